// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: states, opcodes,
// ALU operation codes, immediate formats and datapath mux selects.
package riscv_mc_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned ALUCTL_W = 4;
    localparam int unsigned IMM_W    = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        LUI,
        ALUWB,
        BRANCH,
        JALR,
        JAL,
        TRAP
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

    localparam logic [ALUCTL_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [ALUCTL_W-1:0] ALU_AND   = 4'b0010;
    localparam logic [ALUCTL_W-1:0] ALU_OR    = 4'b0011;
    localparam logic [ALUCTL_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [ALUCTL_W-1:0] ALU_SLT   = 4'b0101;
    localparam logic [ALUCTL_W-1:0] ALU_SLL   = 4'b0110;
    localparam logic [ALUCTL_W-1:0] ALU_SRL   = 4'b0111;
    localparam logic [ALUCTL_W-1:0] ALU_SRA   = 4'b1000;
    localparam logic [ALUCTL_W-1:0] ALU_PASSB = 4'b1001;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode into an ALU operation code; flags the
// funct3 encoding this core does not implement.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                rtype,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal
);

    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (funct3)
            3'b000:  alucontrol = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alucontrol = ALU_SLL;
            3'b010:  alucontrol = ALU_SLT;
            3'b100:  alucontrol = ALU_XOR;
            3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alucontrol = ALU_OR;
            3'b111:  alucontrol = ALU_AND;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives datapath selects and strobes decoded from the current state.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                MemReq,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [IMM_W-1:0]    ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                IllegalInstr
);

    state_t                state;
    state_t                next_state;
    logic                  illegal_q;
    logic [ALUCTL_W-1:0]   dec_ctl;
    logic                  dec_illegal;

    alu_decoder u_alu_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .rtype      (op == OP_RTYPE),
        .alucontrol (dec_ctl),
        .illegal    (dec_illegal)
    );

    // State register; the illegal flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign IllegalInstr = illegal_q;

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = ADR_PC;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;

        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                AdrSrc    = ADR_PC;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // ALUOut gets the branch (or JAL) target from OldPC + imm.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_LUI:            next_state = LUI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR;
                    default:           next_state = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = ADR_ALUOUT;
                if (MemReady) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = RES_RDATA;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = ADR_ALUOUT;
                if (MemReady) begin
                    next_state = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = dec_ctl;
                next_state = dec_illegal ? TRAP : ALUWB;
            end
            EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = dec_ctl;
                next_state = dec_illegal ? TRAP : ALUWB;
            end
            LUI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                ALUControl = ALU_PASSB;
                next_state = ALUWB;
            end
            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                case (funct3)
                    3'b000: begin
                        PCWrite    = Zero;
                        next_state = FETCH;
                    end
                    3'b001: begin
                        PCWrite    = ~Zero;
                        next_state = FETCH;
                    end
                    default: next_state = TRAP;
                endcase
            end
            JALR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                next_state = JAL;
            end
            JAL: begin
                // PC takes the target held in ALUOut; ALU forms the link value.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // Reset silences every control, including the fetch request.
        if (reset) begin
            MemReq     = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = '0;
            ALUSrcA    = '0;
            ALUSrcB    = '0;
            ImmSrc     = '0;
            ALUControl = '0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-002 The ports SHALL be:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
op  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU result equals zero
MemReady  in  1  memory access completes this cycle
MemReq  out  1  memory access request
MemWrite  out  1  store strobe, valid with MemReq
AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
IRWrite  out  1  load instruction register and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register file write enable
ResultSrc  out  2  result select: 00 ALUOut, 01 read data, 10 ALUResult
ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  ALU B select: 00 RD2, 01 Imm, 10 constant 4
ImmSrc  out  3  immediate format: I 000, S 001, B 010, J 011, U 100
ALUControl  out  4  ALU operation code
IllegalInstr  out  1  sticky illegal-instruction flag

Function
REQ-003 The states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, LUI, ALUWB, BRANCH, JALR, JAL and TRAP.
REQ-004 Outputs SHALL default to 0 and ALUControl to ADD; each state drives only the outputs listed for it.
REQ-005 FETCH SHALL drive MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, and IRWrite=PCWrite=MemReady; the state stays FETCH while MemReady=0 and moves to DECODE on MemReady=1.
REQ-006 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=B (branch target into ALUOut), then dispatch on op: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 0110111→LUI, 1100011→BRANCH, 1101111→JAL, 1100111→JALR, any other op→TRAP.
REQ-007 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=I for a load or S for a store, and go to MEMREAD for a load or MEMWRITE for a store.
REQ-008 MEMREAD SHALL drive MemReq=1, AdrSrc=1 and hold until MemReady=1, then go to MEMWB; MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-009 MEMWRITE SHALL drive MemReq=1, MemWrite=1, AdrSrc=1 and hold until MemReady=1, then go to FETCH.
REQ-010 EXECR (ALUSrcA=10, ALUSrcB=00) and EXECI (ALUSrcA=10, ALUSrcB=01, ImmSrc=I) SHALL drive the decoded ALUControl and go to ALUWB; LUI SHALL drive ALUSrcB=01, ImmSrc=U, ALUControl=PASSB and go to ALUWB.
REQ-011 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-012 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00, with PCWrite=Zero for funct3=000, PCWrite=~Zero for funct3=001, then go to FETCH; any other funct3 SHALL go to TRAP without PCWrite.
REQ-013 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=I (target into ALUOut), then go to JAL.
REQ-014 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 (PC←target, ALUOut←OldPC+4), then go to ALUWB.
REQ-015 When entered from DECODE, JAL SHALL use the J-immediate target; DECODE SHALL therefore drive ImmSrc=J when op=1101111.
REQ-016 ALU decode SHALL map as follows:
- R-type: funct3 000 → ADD, or SUB when funct7b5=1; 001 → SLL; 010 → SLT; 100 → XOR; 101 → SRL, or SRA when funct7b5=1; 110 → OR; 111 → AND.
- I-type: same map, except 000 → ADD always.
- Unlisted funct3 (011) SHALL go to TRAP.
REQ-017 ALUControl codes SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, PASSB 1001.
REQ-018 TRAP SHALL hold with all strobes 0 and IllegalInstr=1 until reset.
REQ-019 MemReady SHALL be ignored in states without MemReq.

Reset
REQ-020 Reset SHALL asynchronously force the state to FETCH and IllegalInstr to 0.
REQ-021 While reset is high, every output SHALL be 0, including MemReq.
REQ-022 Reset asserted mid-access SHALL abandon the access, with no PCWrite or RegWrite issued.

Structure
REQ-023 The state enum, opcode constants, ALUControl codes, ImmSrc codes and mux select codes SHALL reside in a shared package, riscv_mc_pkg.
REQ-024 The ALU decode SHALL be one combinational sub-module, alu_decoder.

Verification
REQ-025 Release reset with MemReady=1 and op=0110011, funct3=000, funct7b5=1 → FETCH, DECODE, EXECR (ALUControl=0001), ALUWB (RegWrite=1), FETCH.
REQ-026 Run lw with MemReady low for 3 cycles in MEMREAD → MemReq=1 and AdrSrc=1 for 4 cycles, MEMWB for one cycle, then FETCH.
REQ-027 Run a branch with funct3=001: Zero=0 → PCWrite=1 in BRANCH; Zero=1 → PCWrite=0.
REQ-028 Run jalr → DECODE, JALR, JAL (PCWrite=1), ALUWB (RegWrite=1), FETCH; total 5 cycles with zero-wait memory.
REQ-029 Apply op=1111111 → TRAP, IllegalInstr=1 held for 10 cycles; asynchronous reset → IllegalInstr=0 and state FETCH.
REQ-030 Assert reset in MEMWRITE with MemReady=0 → all outputs 0 immediately; after release, FETCH.
